// File: rtl/dac_stream_scheduler.sv
// dac_stream_scheduler: buffers 8-bit slices of FIR samples and paces them out to a DAC driver.
// Latency: a tick in cycle N gives DAC_Start=1 and valid DAC_Data in cycle N+1; a pushed sample is poppable one cycle later.
// Backpressure: s_tready drops while the FIFO is full; late ticks are dropped and flagged, never queued.
//
// Optional build macro: DAC_SCHED_SAT_EN (saturate the slice instead of truncating it).
//
// Ports:
//   clk_100MHz  system clock, rising edge         Rst         synchronous active-low reset
//   s_tvalid/s_tready/s_tdata  FIR sample stream  Shift       LSB index of the 8-bit slice
//   Period      DAC update interval in clocks     DAC_Busy    DAC driver conversion in progress
//   DAC_Start   one-cycle conversion request      DAC_Data    offset-binary code to DAC driver
//   Clr_Status  clears sticky flags               Status      [0] Underrun, [1] Tick_Miss
//   Fill_Level  FIFO occupancy
module dac_stream_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD_MIN = 2
) (
  input  logic        clk_100MHz,
  input  logic        Rst,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [23:0] s_tdata,
  input  logic [3:0]  Shift,
  input  logic [15:0] Period,
  input  logic        DAC_Busy,
  output logic        DAC_Start,
  output logic [7:0]  DAC_Data,
  input  logic        Clr_Status,
  output logic [1:0]  Status,
  output logic [4:0]  Fill_Level
);

  localparam int         AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);
  localparam logic [15:0] PMIN  = 16'(PERIOD_MIN);

  typedef enum logic [1:0] {IDLE, START, ACK, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [4:0]  count_q;
  logic        rdy_q;
  logic [15:0] cnt_q, per_q;
  logic [7:0]  data_q;
  logic [1:0]  status_q;

  logic        push, pop, tick;
  logic        underrun_set, miss_set;
  logic [4:0]  sh;
  logic [7:0]  slice;
  logic [7:0]  push_code;
  logic [15:0] per_eff;

  // Shift is clamped to 16 so the slice never runs past bit 23.
  assign sh = ({1'b0, Shift} > 5'd16) ? 5'd16 : {1'b0, Shift};

`ifdef DAC_SCHED_SAT_EN
  logic [23:0] shifted;
  logic        ovf;
  // Arithmetic shift: bits [23:7] are s_tdata[23:sh+7] plus sign copies,
  // so they are all equal exactly when the slice represents the value.
  assign shifted   = $signed(s_tdata) >>> sh;
  assign slice     = shifted[7:0];
  assign ovf       = ~((&shifted[23:7]) | ~(|shifted[23:7]));
  assign push_code = ovf ? (s_tdata[23] ? 8'h00 : 8'hFF) : {~slice[7], slice[6:0]};
`else
  assign slice     = 8'(s_tdata >> sh);
  assign push_code = {~slice[7], slice[6:0]};
`endif

  // rdy_q keeps s_tready low through reset and for the reset cycle itself.
  assign s_tready   = rdy_q && (count_q != DEPTH5);
  assign push       = s_tvalid && s_tready;
  assign Fill_Level = count_q;
  assign DAC_Data   = data_q;
  assign Status     = status_q;

  // Interval is latched at wrap, so a Period change never shortens the current interval.
  assign per_eff = (Period < PMIN) ? PMIN : Period;
  assign tick    = (cnt_q == per_q - 16'd1);

  always_ff @(posedge clk_100MHz) begin
    if (push) begin
      mem_q[wr_q] <= push_code;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!Rst) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
      cnt_q    <= '0;
      per_q    <= per_eff;
      data_q   <= 8'h80;
      status_q <= 2'b00;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q   <= rd_q + AW'(1);
        data_q <= mem_q[rd_q];
      end
      count_q <= count_q + {4'b0, push} - {4'b0, pop};
      if (tick) begin
        cnt_q <= '0;
        per_q <= per_eff;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
      // Set wins over a simultaneous clear.
      status_q <= (status_q & ~{2{Clr_Status}}) | {miss_set, underrun_set};
    end
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    underrun_set = 1'b0;
    miss_set     = 1'b0;
    DAC_Start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = START;
          // Empty FIFO: DAC_Data is left alone, so the last code is re-issued.
          if (count_q != 5'd0) pop = 1'b1;
          else                 underrun_set = 1'b1;
        end
      end
      START: begin
        DAC_Start = 1'b1;
        miss_set  = tick;
        state_d   = ACK;
      end
      ACK: begin
        miss_set = tick;
        if (DAC_Busy) state_d = DONE;
      end
      DONE: begin
        miss_set = tick;
        if (!DAC_Busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/dac_stream_scheduler.md
DAC_STREAM_SCHEDULER -- requirements
Module: dac_stream_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning sample-buffer depth in 8-bit entries (power of two, 2..16).
REQ-002 SHALL have parameter PERIOD_MIN, default 2, meaning smallest honoured DAC update interval in clocks.
REQ-003 SHALL have port clk_100MHz  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port Rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port s_tvalid  input  1  FIR output sample valid.
REQ-006 SHALL have port s_tready  output  1  scheduler can accept a sample.
REQ-007 SHALL have port s_tdata  input  24  signed FIR output sample.
REQ-008 SHALL have port Shift  input  4  LSB index of the 8-bit slice taken from s_tdata (0..16).
REQ-009 SHALL have port Period  input  16  DAC update interval in clocks.
REQ-010 SHALL have port DAC_Busy  input  1  DAC driver conversion in progress.
REQ-011 SHALL have port DAC_Start  output  1  one-cycle conversion request to DAC driver.
REQ-012 SHALL have port DAC_Data  output  8  offset-binary code for DAC driver.
REQ-013 SHALL have port Clr_Status  input  1  clears sticky status bits.
REQ-014 SHALL have port Status  output  2  sticky flags: [0] Underrun, [1] Tick_Miss.
REQ-015 SHALL have port Fill_Level  output  5  current FIFO occupancy.

Function
REQ-016 Slice: s_tdata[Shift+7:Shift] taken at push; Shift>16 treated as 16; slice MSB inverted (two's complement to offset binary) before storage.
REQ-017 FIFO: push when s_tvalid && s_tready; s_tready = (Fill_Level != FIFO_DEPTH); pop only in state START entry; no bypass, so a sample pushed in cycle N is first poppable in N+1.
REQ-018 Tick counter: counts 0..P-1, where P = max(Period, PERIOD_MIN); tick asserted for one cycle when count == P-1; count then wraps to 0; Period change takes effect at next wrap.
REQ-019 FSM states IDLE, START, ACK, DONE.
REQ-020 IDLE: on tick with FIFO non-empty -> pop, load DAC_Data, go START; on tick with FIFO empty -> set Underrun, hold DAC_Data unchanged, re-issue it, go START.
REQ-021 START: DAC_Start=1 for exactly this one cycle; next state ACK.
REQ-022 ACK: wait DAC_Busy=1 -> DONE; DONE: wait DAC_Busy=0 -> IDLE.
REQ-023 Tick occurring in START, ACK or DONE is dropped and sets Tick_Miss; no queued retry.
REQ-024 Status bits sticky until Clr_Status=1; set and clear in same cycle -> set wins.
REQ-025 DAC_Data SHALL change only on transition IDLE->START.
REQ-026 Latency: tick in cycle N -> DAC_Start=1 in cycle N+1, DAC_Data valid from N+1.

Reset
REQ-027 On Rst=0 at clock edge: FSM=IDLE, tick counter=0, FIFO emptied, Fill_Level=0, s_tready=0 during reset then 1 the cycle after release, DAC_Start=0, DAC_Data=8'h80 (mid-scale), Status=2'b00.
REQ-028 Reset mid-conversion SHALL abort to IDLE without waiting for DAC_Busy to fall.

Configuration
REQ-029 Macro DAC_SCHED_SAT_EN: when defined, slice saturates -- if s_tdata[23:Shift+7] is not all equal, stored value clamps to 8'hFF (positive) or 8'h00 (negative) after offset conversion; when undefined, plain truncation of the slice.

Verification
REQ-030 Period=10, 3 samples pushed, DAC_Busy high 3 cycles after each start -> DAC_Start pulses at cycles 10, 20, 30 after reset release; fourth tick with empty FIFO sets Status[0], re-issues last code.
REQ-031 s_tdata=24'h000400, Shift=10 -> DAC_Data=8'h81; s_tdata=24'hFFFC00, Shift=10 -> 8'h7F.
REQ-032 DAC_SCHED_SAT_EN defined, Shift=10, s_tdata=24'h040000 -> 8'hFF; 24'hF80000 -> 8'h00; undefined -> truncated values 8'h80 and 8'h80.
REQ-033 Push 5 samples back-to-back, no ticks -> s_tready falls after fourth, Fill_Level=4, fifth held until a pop.
REQ-034 Period=4, DAC_Busy held high 10 cycles -> Status[1]=1; Clr_Status pulse -> Status[1]=0; Period=0 -> tick every 2 clocks.
REQ-035 Rst=0 asserted during DONE -> next cycle IDLE, DAC_Data=8'h80, Fill_Level=0.
